// File: rtl/frame_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_writer
// Description : Write-side front end for the frame/sprite block RAM.
//               Pixel write requests (x, y, colour) arrive over a valid/ready
//               handshake, are buffered in a small FIFO, converted to a linear
//               address (y*H_PIX + x) and written through the RAM write port.
//               A clear command fills the entire buffer with one colour after
//               all already-queued pixels have been written.
// Ports       : clk, rst                  - clock, synchronous active-high reset
//               wr_valid/wr_ready         - request handshake
//               wr_x, wr_y, wr_color      - request payload
//               clr_req, clr_color        - clear command pulse and fill colour
//               busy                      - work queued or in flight
//               clr_done                  - pulse after the last clear write
//               oob_err                   - pulse when a popped request is dropped
//               mem_we, mem_addr, mem_din - registered RAM write port
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer_writer #(
    parameter int width_base = 12,
    parameter int depth_base = 10,
    parameter int H_PIX      = 32,
    parameter int V_PIX      = 32,
    parameter int X_BITS     = 6,
    parameter int Y_BITS     = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [X_BITS-1:0]     wr_x,
    input  logic [Y_BITS-1:0]     wr_y,
    input  logic [width_base-1:0] wr_color,
    input  logic                  clr_req,
    input  logic [width_base-1:0] clr_color,
    output logic                  busy,
    output logic                  clr_done,
    output logic                  oob_err,
    output logic                  mem_we,
    output logic [depth_base-1:0] mem_addr,
    output logic [width_base-1:0] mem_din
);

    // FIFO_DEPTH is a power of two (>= 2) so the pointers wrap naturally.
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W:0]        c_fifo_depth = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [X_BITS:0]       c_x_lim      = (X_BITS+1)'(H_PIX);
    localparam logic [Y_BITS:0]       c_y_lim      = (Y_BITS+1)'(V_PIX);
    localparam logic [depth_base-1:0] c_h_pix      = depth_base'(H_PIX);
    // One bit wider than the address so the terminal count is representable.
    localparam logic [depth_base:0]   c_total      = (depth_base+1)'(H_PIX*V_PIX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_clr_pending;
    logic [width_base-1:0] r_clr_color;
    logic [depth_base:0]   r_clr_cnt;

    // Request FIFO storage and bookkeeping.
    logic [X_BITS-1:0]     r_fifo_x [FIFO_DEPTH];
    logic [Y_BITS-1:0]     r_fifo_y [FIFO_DEPTH];
    logic [width_base-1:0] r_fifo_c [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [PTR_W:0]        r_count;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic [X_BITS-1:0]     w_head_x;
    logic [Y_BITS-1:0]     w_head_y;
    logic [width_base-1:0] w_head_c;
    logic                  w_in_range;
    logic [depth_base-1:0] w_head_addr;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_fifo_depth);

    // Depends on registered state only, never on wr_valid.
    assign wr_ready = !w_full && !r_clr_pending && (r_state != ST_CLEAR);

    assign w_push   = wr_valid && wr_ready;
    assign w_pop    = (r_state == ST_WRITE) && !w_empty;

    assign w_head_x = r_fifo_x[r_rptr];
    assign w_head_y = r_fifo_y[r_rptr];
    assign w_head_c = r_fifo_c[r_rptr];

    assign w_in_range = ({1'b0, w_head_x} < c_x_lim) && ({1'b0, w_head_y} < c_y_lim);

    // Modular arithmetic: the low depth_base bits of the wider product/sum are
    // identical, so computing directly at address width gives the truncated
    // linear address.
    assign w_head_addr = ({{(depth_base-Y_BITS){1'b0}}, w_head_y} * c_h_pix)
                       + {{(depth_base-X_BITS){1'b0}}, w_head_x};

    assign busy = !w_empty || r_clr_pending || (r_state != ST_IDLE) || mem_we;

    // FIFO payload storage; no reset needed, validity tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_x[r_wptr] <= wr_x;
            r_fifo_y[r_wptr] <= wr_y;
            r_fifo_c[r_wptr] <= wr_color;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_clr_pending <= 1'b0;
            r_clr_color   <= '0;
            r_clr_cnt     <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_din       <= '0;
            oob_err       <= 1'b0;
            clr_done      <= 1'b0;
        end else begin
            mem_we   <= 1'b0;
            oob_err  <= 1'b0;
            clr_done <= 1'b0;

            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};

            // A clear already pending or running swallows further commands
            // without touching the latched colour.
            if (clr_req && !r_clr_pending && (r_state != ST_CLEAR)) begin
                r_clr_pending <= 1'b1;
                r_clr_color   <= clr_color;
            end

            case (r_state)
                ST_IDLE: begin
                    // Queued pixels take priority so that a request accepted
                    // alongside clr_req is still written before the fill.
                    if (!w_empty) begin
                        r_state <= ST_WRITE;
                    end else if (r_clr_pending) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= '0;
                    end
                end

                ST_WRITE: begin
                    if (!w_empty) begin
                        if (w_in_range) begin
                            mem_we   <= 1'b1;
                            mem_addr <= w_head_addr;
                            mem_din  <= w_head_c;
                        end else begin
                            oob_err  <= 1'b1;
                        end
                    end else if (r_clr_pending) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_CLEAR: begin
                    if (r_clr_cnt != c_total) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= r_clr_cnt[depth_base-1:0];
                        mem_din   <= r_clr_color;
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end else begin
                        // Last address was written on the previous edge.
                        clr_done      <= 1'b1;
                        r_clr_pending <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_buffer_writer
// Description : Self-checking bench for frame_buffer_writer. Stimulus pushes
//               the expected RAM-port events into a scoreboard queue; a
//               negedge monitor pops and compares whenever the DUT writes,
//               flags an out-of-range drop, or finishes a clear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buffer_writer;

    localparam int HP = 32;
    localparam int VP = 32;

    localparam int EV_WR   = 0;
    localparam int EV_OOB  = 1;
    localparam int EV_DONE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [5:0]  wr_x = '0;
    logic [5:0]  wr_y = '0;
    logic [11:0] wr_color = '0;
    logic        clr_req = 1'b0;
    logic [11:0] clr_color = '0;
    logic        busy;
    logic        clr_done;
    logic        oob_err;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [11:0] mem_din;

    frame_buffer_writer #(
        .width_base (12),
        .depth_base (10),
        .H_PIX      (HP),
        .V_PIX      (VP),
        .X_BITS     (6),
        .Y_BITS     (6),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_color  (wr_color),
        .clr_req   (clr_req),
        .clr_color (clr_color),
        .busy      (busy),
        .clr_done  (clr_done),
        .oob_err   (oob_err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int addr;
        int data;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;
    int  checks = 0;
    int  errors = 0;
    bit  m_clr_busy = 1'b0;   // model: a clear is pending or running

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pixel (x,y) lands at y*HP+x when inside the buffer,
    // otherwise it is dropped with an error pulse.
    task automatic push_req(input int x, input int y, input int c);
        if (x < HP && y < VP) q.push_back('{EV_WR, y * HP + x, c});
        else                  q.push_back('{EV_OOB, 0, 0});
    endtask

    task automatic push_clear(input int c);
        for (int a = 0; a < HP * VP; a++) q.push_back('{EV_WR, a, c});
        q.push_back('{EV_DONE, 0, 0});
        m_clr_busy = 1'b1;
    endtask

    // Drive one cycle of inputs (called at posedge+1) and model its effect.
    task automatic step(input bit v, input int x, input int y, input int c,
                        input bit cr, input int cc, output bit acc);
        wr_valid  = v;
        wr_x      = 6'(x);
        wr_y      = 6'(y);
        wr_color  = 12'(c);
        clr_req   = cr;
        clr_color = 12'(cc);
        acc = v && wr_ready;
        @(posedge clk); #1;
        if (acc) push_req(x, y, c);
        if (cr && !m_clr_busy) push_clear(cc);
        wr_valid = 1'b0;
        clr_req  = 1'b0;
    endtask

    task automatic send(input int x, input int y, input int c);
        bit acc;
        for (int i = 0; i < 3000; i++) begin
            step(1'b1, x, y, c, 1'b0, 0, acc);
            if (acc) return;
        end
        checks++; errors++;
        $display("FAIL send_timeout: request x=%0d y=%0d not accepted, expected acceptance", x, y);
    endtask

    task automatic wait_write_at(input int addr, input int data, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (mem_we && mem_addr == 10'(addr) && mem_din == 12'(data)) begin
                found = 1'b1;
                break;
            end
        end
        check(name, int'(found), 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 6000; i++) begin
            if (q.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain_queue_empty", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", int'(busy), 0);
    endtask

    // Monitor: every DUT output event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we || oob_err || clr_done) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: we=%0b oob=%0b done=%0b addr=%0d, expected no output",
                             mem_we, oob_err, clr_done, mem_addr);
                end else begin
                    mon_e = q.pop_front();
                    check("event_kind", int'({mem_we, oob_err, clr_done}),
                          (mon_e.kind == EV_WR) ? 4 : (mon_e.kind == EV_OOB) ? 2 : 1);
                    if (mon_e.kind == EV_WR) begin
                        check("write_addr", int'(mem_addr), mon_e.addr);
                        check("write_data", int'(mem_din), mon_e.data);
                    end
                    if (mon_e.kind == EV_DONE) m_clr_busy = 1'b0;
                end
            end
            if (m_clr_busy) check("ready_low_during_clear", int'(wr_ready), 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit acc;
        bit have_req;
        int rx, ry, rc;

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_we", int'(mem_we), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", int'(wr_ready), 1);
        check("post_rst_addr", int'(mem_addr), 0);
        check("post_rst_din", int'(mem_din), 0);
        check("post_rst_pulses", int'({oob_err, clr_done, mem_we, busy}), 0);

        // Single request: write appears on the 3rd edge after acceptance
        step(1'b1, 3, 2, 12'hF00, 1'b0, 0, acc);
        check("t1_accept", int'(acc), 1);
        check("t1_edge1_we", int'(mem_we), 0);
        @(posedge clk); #1;
        check("t1_edge2_we", int'(mem_we), 0);
        @(posedge clk); #1;
        check("t1_edge3_we", int'(mem_we), 1);
        check("t1_edge3_addr", int'(mem_addr), 67);
        check("t1_edge3_din", int'(mem_din), 12'hF00);
        @(posedge clk); #1;
        check("t1_edge4_we", int'(mem_we), 0);
        drain();

        // Back-to-back requests, in order, one per cycle
        for (int i = 0; i < 6; i++) send(i + 1, 10, 12'h100 + i);
        drain();

        // Out-of-range entry between two valid ones
        send(1, 1, 12'h0A0);
        send(40, 5, 12'h555);
        send(2, 1, 12'h0B0);
        drain();

        // Two queued pixels (second with clr_req), then a full clear;
        // a second clear command part-way through is ignored
        send(4, 4, 12'h123);
        step(1'b1, 5, 4, 12'h456, 1'b1, 12'h00F, acc);
        check("t4_simul_accept", int'(acc), 1);
        wait_write_at(100, 12'h00F, "t4_clear_reaches_100");
        @(posedge clk); #1;
        step(1'b0, 0, 0, 0, 1'b1, 12'hFFF, acc);
        drain();

        // Reset in the middle of a clear
        step(1'b0, 0, 0, 0, 1'b1, 12'h0A5, acc);
        wait_write_at(500, 12'h0A5, "t5_clear_reaches_500");
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        q.delete();
        m_clr_busy = 1'b0;
        check("t5_rst_we_low", int'(mem_we), 0);
        check("t5_rst_no_done", int'(clr_done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t5_ready_after_rst", int'(wr_ready), 1);
        repeat (5) @(posedge clk);
        #1;
        send(31, 31, 12'h321);
        drain();

        // Randomized traffic with occasional clears
        have_req = 1'b0;
        rx = 0; ry = 0; rc = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!have_req && $urandom_range(0, 3) != 0) begin
                have_req = 1'b1;
                rx = int'($urandom_range(0, 39));
                ry = int'($urandom_range(0, 39));
                rc = int'($urandom_range(0, 4095));
            end
            step(have_req, rx, ry, rc, ($urandom_range(0, 599) == 0),
                 int'($urandom_range(0, 4095)), acc);
            if (acc) have_req = 1'b0;
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
